fc_dense_neuron_array: RTL

//   Parametrised fully-connected layer slice: NUM_NEURONS IEEE-754 fp32 neurons share one

---
 rtl/fc_dense_neuron_array_pkg.sv | 101 ++++++++++
 rtl/fc_dense_neuron_array_mac_lane.sv | 29 ++
 rtl/fc_dense_neuron_array.sv | 85 ++++++++
 3 files changed

// File: rtl/fc_dense_neuron_array_pkg.sv
// Shared fp32 constants, activation selectors and combinational fp32 multiply/add helpers
// for the dense neuron array.
package fc_dense_neuron_array_pkg;

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam int          FP32_SIGN_BIT = 31;
  localparam int          ACT_LINEAR    = 0;
  localparam int          ACT_RELU      = 1;

  // Truncating fp32 multiply; subnormals flush to signed zero, NaN operands pass through.
  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea, eb;
    logic [22:0]       ma, mb, m;
    logic [47:0]       prod;
    logic signed [9:0] e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    ma = a[22:0];
    mb = b[22:0];
    if (ea == 8'hFF && ma != '0) return a;
    if (eb == 8'hFF && mb != '0) return b;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (ea == 8'h00 || eb == 8'h00) return FP32_QNAN;
      return {s, 8'hFF, 23'h0};
    end
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
    prod = {1'b1, ma} * {1'b1, mb};
    e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 10'sd1;
    end else begin
      m = prod[45:23];
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
    if (e <= 10'sd0)   return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  // Truncating fp32 add; larger-magnitude operand sets the result sign.
  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [26:0]       mx, my;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [22:0]       m;
    logic signed [9:0] e;
    ea = a[30:23];
    eb = b[30:23];
    if (ea == 8'hFF && a[22:0] != '0) return a;
    if (eb == 8'hFF && b[22:0] != '0) return b;
    if (ea == 8'hFF && eb == 8'hFF) return (a[31] != b[31]) ? FP32_QNAN : a;
    if (ea == 8'hFF) return a;
    if (eb == 8'hFF) return b;
    if (ea == 8'h00 && eb == 8'h00) return {a[31] & b[31], 31'h0};
    if (ea == 8'h00) return b;
    if (eb == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[30:23];
    ey = y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = ex - ey;
    my = (d >= 8'd27) ? '0 : (my >> d);
    e  = $signed({2'b00, ex});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        m = sum[26:4];
        e = e + 10'sd1;
      end else begin
        m = sum[25:3];
      end
    end else begin
      sum = {1'b0, mx - my};
      if (sum == '0) return FP32_ZERO;
      lz = '0;
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      sum = sum << lz;
      m   = sum[25:3];
      e   = e - $signed({5'b00000, lz});
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'h0};
    if (e <= 10'sd0)   return {x[31], 31'h0};
    return {x[31], e[7:0], m};
  endfunction

endpackage

// File: rtl/fc_dense_neuron_array_mac_lane.sv
// One neuron lane: fp32 multiply-accumulate into a bias-initialised accumulator.
module fc_mac_lane
  import fc_dense_neuron_array_pkg::*;
#(
  parameter logic [31:0] BIAS = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_bias,
  input  logic        accum,
  input  logic [31:0] data_in,
  input  logic [31:0] weight,
  output logic [31:0] sum
);

  logic [31:0] acc;

  assign sum = fp32_add(acc, fp32_mul(data_in, weight));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || load_bias) begin
      acc <= BIAS;
    end else if (accum) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fc_dense_neuron_array.sv
// Fully-connected layer slice: NUM_NEURONS fp32 MAC lanes share one input stream and
// publish their sums (optionally ReLU'd) after NUM_INPUTS accepted samples.
module fc_dense_neuron_array
  import fc_dense_neuron_array_pkg::*;
#(
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            NUM_NEURONS = 2,
  parameter int                            NUM_INPUTS  = 64,
  parameter logic [NUM_NEURONS*32-1:0]     BIAS_VEC    = '0,
  parameter int                            ACT         = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] weight,
  output logic                              valid_out,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] data_out,
  output logic                              busy
);

  localparam int                CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_INPUTS - 1);

  logic [CNT_W-1:0]                   cnt;
  logic                               take;
  logic                               last_sample;
  logic [NUM_NEURONS-1:0][31:0]       lane_sum;
  logic [NUM_NEURONS-1:0][31:0]       act_out;

  // clear beats valid_in, so a sample arriving with clear is simply dropped.
  assign take        = valid_in && !clear;
  assign last_sample = take && (cnt == LAST);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    fc_mac_lane #(
      .BIAS (BIAS_VEC[n*32 +: 32])
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load_bias (clear || last_sample),
      .accum     (take),
      .data_in   (data_in[31:0]),
      .weight    (weight[n*DATA_WIDTH +: 32]),
      .sum       (lane_sum[n])
    );
  end

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    act_out = lane_sum;
    if (ACT == ACT_RELU) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (lane_sum[n][FP32_SIGN_BIT]) act_out[n] = FP32_ZERO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else if (valid_in) begin
        if (last_sample) begin
          data_out  <= act_out;
          valid_out <= 1'b1;
          cnt       <= '0;
          busy      <= 1'b0;
        end else begin
          cnt  <= cnt + 1'b1;
          busy <= 1'b1;
        end
      end
    end
  end

endmodule
